// File: rtl/ysyx_25060170_div_iter.sv
// Iterative radix-2 restoring divider for the RV64M execute stage.
// Computes DIV/DIVU/REM/REMU and their W variants. Each division produces one
// quotient bit per clock. Divide-by-zero and signed overflow are resolved at
// accept time.
//
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   div_valid    request strobe, sampled only in IDLE
//   flush        abort any operation in flight; beats div_valid in IDLE
//   div_signed   1 = signed (DIV/REM[W]), 0 = unsigned
//   divw         1 = 32-bit word operation
//   div_op1      dividend
//   div_op2      divisor
//   out_valid    one-cycle completion pulse
//   quotient     registered quotient, held until the next completion
//   remainder    registered remainder, held until the next completion
module ysyx_25060170_div_iter #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            div_valid,
  input  logic            flush,
  input  logic            div_signed,
  input  logic            divw,
  input  logic [XLEN-1:0] div_op1,
  input  logic [XLEN-1:0] div_op2,
  output logic            out_valid,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int unsigned CntW = $clog2(XLEN);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e state_q, state_d;

  logic [CntW-1:0] cnt_q;
  logic [XLEN-1:0] rem_q;   // partial remainder
  logic [XLEN-1:0] dvd_q;   // dividend shifts out at the top, quotient bits shift in at the bottom
  logic [XLEN-1:0] dvs_q;
  logic            q_neg_q, r_neg_q, divw_q;

  function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v);
    return {{(XLEN-32){v[31]}}, v[31:0]};
  endfunction

  // Operand preparation
  logic [XLEN-1:0] op_a, op_b, abs_a, abs_b, min_neg;
  logic            sa, sb, div_zero, overflow, special, accept;
  logic [XLEN-1:0] spec_q, spec_r;

  always_comb begin
    if (divw) begin
      op_a = div_signed ? sext_w(div_op1) : {{(XLEN-32){1'b0}}, div_op1[31:0]};
      op_b = div_signed ? sext_w(div_op2) : {{(XLEN-32){1'b0}}, div_op2[31:0]};
      min_neg = {{(XLEN-31){1'b1}}, 31'b0};
    end else begin
      op_a = div_op1;
      op_b = div_op2;
      min_neg = {1'b1, {(XLEN-1){1'b0}}};
    end
    sa       = div_signed & op_a[XLEN-1];
    sb       = div_signed & op_b[XLEN-1];
    abs_a    = sa ? -op_a : op_a;
    abs_b    = sb ? -op_b : op_b;
    div_zero = (op_b == '0);
    overflow = div_signed & (op_a == min_neg) & (op_b == '1);
    special  = div_zero | overflow;
    spec_q   = div_zero ? '1 : op_a;
    spec_r   = div_zero ? op_a : '0;
    if (divw) begin
      // Word results are always sign-extended from bit 31, unsigned ops included.
      spec_q = sext_w(spec_q);
      spec_r = sext_w(spec_r);
    end
    accept   = (state_q == StIdle) & div_valid & ~flush;
  end

  // One restoring step. The borrow out of the XLEN+1-bit subtraction tells
  // whether the shifted partial remainder was below the divisor.
  logic [XLEN:0]   rem_shift, rem_sub;
  logic            ge;
  logic [XLEN-1:0] rem_next, dvd_next, q_fin, r_fin;

  always_comb begin
    rem_shift = {rem_q, dvd_q[XLEN-1]};
    rem_sub   = rem_shift - {1'b0, dvs_q};
    ge        = ~rem_sub[XLEN];
    rem_next  = ge ? rem_sub[XLEN-1:0] : rem_shift[XLEN-1:0];
    dvd_next  = {dvd_q[XLEN-2:0], ge};
    q_fin     = q_neg_q ? -dvd_next : dvd_next;
    r_fin     = r_neg_q ? -rem_next : rem_next;
    if (divw_q) begin
      q_fin = sext_w(q_fin);
      r_fin = sext_w(r_fin);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = special ? StDone : StCalc;
      StCalc: if (cnt_q == '0) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  // Output logic
  always_comb begin
    out_valid = (state_q == StDone);
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      divw_q    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (accept) begin
      rem_q   <= '0;
      // Word dividends are left-aligned so the first step takes bit 31.
      dvd_q   <= divw ? {abs_a[31:0], {(XLEN-32){1'b0}}} : abs_a;
      dvs_q   <= abs_b;
      q_neg_q <= sa ^ sb;
      r_neg_q <= sa;
      divw_q  <= divw;
      cnt_q   <= divw ? CntW'(31) : CntW'(XLEN - 1);
      if (special) begin
        quotient  <= spec_q;
        remainder <= spec_r;
      end
    end else if ((state_q == StCalc) && !flush) begin
      rem_q <= rem_next;
      dvd_q <= dvd_next;
      if (cnt_q == '0) begin
        quotient  <= q_fin;
        remainder <= r_fin;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25060170_div_iter.sv
module tb_ysyx_25060170_div_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_valid, flush, div_signed, divw;
  logic [63:0] div_op1, div_op2;
  logic        out_valid;
  logic [63:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

  logic [63:0] last_q, last_r;

  always #5 clk = ~clk;

  ysyx_25060170_div_iter #(.XLEN(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .div_valid (div_valid),
    .flush     (flush),
    .div_signed(div_signed),
    .divw      (divw),
    .div_op1   (div_op1),
    .div_op2   (div_op2),
    .out_valid (out_valid),
    .quotient  (quotient),
    .remainder (remainder)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // out_valid must never be high on two consecutive cycles
  logic prev_ov = 1'b0;
  always @(negedge clk) begin
    if (out_valid === 1'b1) chk("out_valid_single_pulse", {63'b0, prev_ov}, 64'd0);
    prev_ov <= (out_valid === 1'b1);
  end

  function automatic logic [63:0] sx32(input logic [63:0] v);
    return {{32{v[31]}}, v[31:0]};
  endfunction

  // Reference model: RISC-V M-extension semantics in plain arithmetic
  task automatic model(input logic [63:0] a, input logic [63:0] b, input logic s,
                       input logic w, output logic [63:0] q, output logic [63:0] r,
                       output int lat);
    logic [63:0] ea, eb, mn;
    logic signed [63:0] sa_v, sb_v;
    ea = w ? (s ? sx32(a) : {32'b0, a[31:0]}) : a;
    eb = w ? (s ? sx32(b) : {32'b0, b[31:0]}) : b;
    mn = w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    if (eb == 64'd0) begin
      q = '1; r = ea; lat = 1;
    end else if (s && eb == '1 && ea == mn) begin
      q = ea; r = 64'd0; lat = 1;
    end else begin
      lat = w ? 33 : 65;
      if (s) begin
        sa_v = ea; sb_v = eb;
        q = sa_v / sb_v;
        r = sa_v % sb_v;
      end else begin
        q = ea / eb;
        r = ea % eb;
      end
    end
    if (w) begin
      q = sx32(q);
      r = sx32(r);
    end
  endtask

  // Starts at a negedge, ends at a negedge.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic s,
                        input logic w, input logic [63:0] eq, input logic [63:0] er,
                        input int lat, input string name);
    int cyc;
    div_op1 = a; div_op2 = b; div_signed = s; divw = w; div_valid = 1'b1;
    @(negedge clk);
    div_valid = 1'b0;
    div_op1 = $urandom; div_op2 = $urandom;
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (out_valid !== 1'b1) begin
      errors++;
      checks++;
      $display("FAIL %s_timeout: got no out_valid expected latency %0d", name, lat);
    end else begin
      chk({name, "_latency"}, 64'(cyc), 64'(lat));
      chk({name, "_q"}, quotient, eq);
      chk({name, "_r"}, remainder, er);
      last_q = eq; last_r = er;
      @(negedge clk);
      chk({name, "_valid_drop"}, {63'b0, out_valid}, 64'd0);
      chk({name, "_q_hold"}, quotient, eq);
    end
  endtask

  task automatic run_model(input logic [63:0] a, input logic [63:0] b, input logic s,
                           input logic w, input string name);
    logic [63:0] q, r;
    int lat;
    model(a, b, s, w, q, r, lat);
    run_op(a, b, s, w, q, r, lat, name);
  endtask

  typedef struct {
    logic [63:0] a, b;
    logic        s, w;
    logic [63:0] q, r;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[9];

  int pulses;

  initial begin
    vecs[0] = '{64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, 65, "divu64"};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0,
                64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65, "div_neg"};
    vecs[2] = '{64'h1234, 64'd0, 1'b1, 1'b0, '1, 64'h1234, 1, "div0"};
    vecs[3] = '{64'h0000_0000_8000_0001, 64'd0, 1'b1, 1'b1,
                '1, 64'hFFFF_FFFF_8000_0001, 1, "div0_w"};
    vecs[4] = '{64'h8000_0000_0000_0000, '1, 1'b1, 1'b0,
                64'h8000_0000_0000_0000, 64'd0, 1, "ovf64"};
    vecs[5] = '{64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b1,
                64'hFFFF_FFFF_8000_0000, 64'd0, 1, "ovf_w"};
    vecs[6] = '{64'hDEAD_BEEF_FFFF_FFFE, 64'd2, 1'b0, 1'b1,
                64'h0000_0000_7FFF_FFFF, 64'd0, 33, "divuw2"};
    vecs[7] = '{64'hDEAD_BEEF_FFFF_FFFE, 64'h10, 1'b0, 1'b1,
                64'h0000_0000_0FFF_FFFF, 64'hE, 33, "divuw16"};
    vecs[8] = '{64'd0, 64'd0, 1'b0, 1'b1, '1, 64'd0, 1, "divuw0_zero"};

    rst = 1'b1; div_valid = 1'b0; flush = 1'b0; div_signed = 1'b0; divw = 1'b0;
    div_op1 = '0; div_op2 = '0;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", {63'b0, out_valid}, 64'd0);
    chk("reset_q", quotient, 64'd0);
    chk("reset_r", remainder, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors
    for (int i = 0; i < 9; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].w, vecs[i].q, vecs[i].r,
             vecs[i].lat, vecs[i].name);

    // Randomized operations against the model
    for (int i = 0; i < 40; i++) begin
      logic [63:0] a, b;
      logic s, w;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      s = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: b = 64'($urandom_range(1, 20));
        1: b = -64'($urandom_range(1, 20));
        2: b = 64'd0;
        3: begin a = w ? 64'h8000_0000 : 64'h8000_0000_0000_0000; b = '1; end
        4: b = {32'b0, $urandom} >> $urandom_range(0, 31);
        default: ;
      endcase
      run_model(a, b, s, w, "rand");
    end

    // Ignore div_valid while busy, then flush mid-CALC
    div_op1 = 64'd1000; div_op2 = 64'd3; div_signed = 1'b0; divw = 1'b0; div_valid = 1'b1;
    pulses = 0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) pulses++;
      div_valid = (c == 5);
      if (c == 5) begin div_op1 = 64'd7; div_op2 = 64'd0; end
      flush = (c == 10);
    end
    chk("flush_no_pulse", 64'(pulses), 64'd0);
    chk("flush_q_hold", quotient, last_q);
    chk("flush_r_hold", remainder, last_r);
    run_op(64'd9, 64'd3, 1'b0, 1'b0, 64'd3, 64'd0, 65, "after_flush");

    // flush together with div_valid in IDLE: request dropped
    div_op1 = 64'd5; div_op2 = 64'd0; div_signed = 1'b1; div_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    div_valid = 1'b0; flush = 1'b0;
    pulses = 0;
    repeat (70) begin
      if (out_valid === 1'b1) pulses++;
      @(negedge clk);
    end
    chk("flush_wins_no_pulse", 64'(pulses), 64'd0);
    chk("flush_wins_q_hold", quotient, last_q);

    // Reset in the middle of CALC, with a concurrent div_valid
    div_op1 = 64'd12345; div_op2 = 64'd7; div_signed = 1'b0; divw = 1'b0; div_valid = 1'b1;
    @(negedge clk);
    div_valid = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1; div_valid = 1'b1; div_op2 = 64'd0;
    @(negedge clk);
    rst = 1'b0; div_valid = 1'b0;
    chk("midreset_out_valid", {63'b0, out_valid}, 64'd0);
    chk("midreset_q", quotient, 64'd0);
    chk("midreset_r", remainder, 64'd0);
    pulses = 0;
    repeat (70) begin
      if (out_valid === 1'b1) pulses++;
      @(negedge clk);
    end
    chk("midreset_no_pulse", 64'(pulses), 64'd0);
    run_model(64'hFFFF_FFFF_FFFF_FF00, 64'd16, 1'b1, 1'b0, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
